// File: rtl/mipi_tx_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mipi_tx_cmd_arbiter_if
// Description : Shared host command port between the arbiter and the host.
// Revision    : 1.0 - initial release
// ============================================================================
interface mipi_tx_cmd_arbiter_if;
    logic        host_tx_cmd_req;
    logic [5:0]  host_tx_cmd_data_type;
    logic [15:0] host_tx_cmd_byte_count;
    logic        host_tx_cmd_ack;
    logic        host_tx_payload_en_last;

    modport master (
        output host_tx_cmd_req,
        output host_tx_cmd_data_type,
        output host_tx_cmd_byte_count,
        input  host_tx_cmd_ack,
        input  host_tx_payload_en_last
    );

    modport slave (
        input  host_tx_cmd_req,
        input  host_tx_cmd_data_type,
        input  host_tx_cmd_byte_count,
        output host_tx_cmd_ack,
        output host_tx_payload_en_last
    );
endinterface
`default_nettype wire

// File: rtl/mipi_tx_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mipi_tx_cmd_arbiter
// Description : Arbitrates video long packets and DCS short packets onto the
//               shared host command port, with vblank priority and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_tx_cmd_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  wire                        clk_periph,
    input  wire                        rstn,
    input  wire                        frame_start,
    input  wire                        vid_req,
    input  wire  [5:0]                 vid_data_type,
    input  wire  [15:0]                vid_byte_count,
    output logic                       vid_ack,
    input  wire                        dcs_req,
    input  wire  [5:0]                 dcs_data_type,
    input  wire  [15:0]                dcs_word,
    output logic                       dcs_ack,
    mipi_tx_cmd_arbiter_if.master      host,
    output logic                       grant_vid,
    output logic                       busy,
    output logic                       timeout_pulse,
    output logic [7:0]                 err_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD_VID  = 2'd1,
        DATA_VID = 2'd2,
        CMD_DCS  = 2'd3
    } state_t;

    localparam logic [15:0] c_wait_last = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ready;
    logic        r_vblank;
    logic [15:0] r_wait_cnt;
    logic        w_grant_vid;
    logic        w_grant_dcs;
    logic        w_vid_done;
    logic        w_dcs_done;
    logic        w_timeout;

    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_vid = 1'b0;
        w_grant_dcs = 1'b0;
        w_vid_done  = 1'b0;
        w_dcs_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                // DCS wins only during vblank or when video is not asking
                if (r_ready && dcs_req && (r_vblank || !vid_req)) begin
                    w_grant_dcs = 1'b1;
                    w_state_nxt = CMD_DCS;
                end else if (r_ready && vid_req) begin
                    w_grant_vid = 1'b1;
                    w_state_nxt = CMD_VID;
                end
            end
            CMD_VID: begin
                if (host.host_tx_cmd_ack) begin
                    w_vid_done  = 1'b1;
                    w_state_nxt = DATA_VID;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DATA_VID: begin
                if (host.host_tx_payload_en_last) w_state_nxt = IDLE;
            end
            CMD_DCS: begin
                if (host.host_tx_cmd_ack) begin
                    w_dcs_done  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_ready holds off granting until the second edge after reset release
    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            r_ready                     <= 1'b0;
            r_vblank                    <= 1'b0;
            r_wait_cnt                  <= 16'd0;
            host.host_tx_cmd_req        <= 1'b0;
            host.host_tx_cmd_data_type  <= 6'd0;
            host.host_tx_cmd_byte_count <= 16'd0;
            vid_ack                     <= 1'b0;
            dcs_ack                     <= 1'b0;
            timeout_pulse               <= 1'b0;
            err_cnt                     <= 8'd0;
        end else begin
            r_ready       <= 1'b1;
            vid_ack       <= w_vid_done;
            dcs_ack       <= w_dcs_done;
            timeout_pulse <= w_timeout;

            if (frame_start)      r_vblank <= 1'b1;
            else if (w_grant_vid) r_vblank <= 1'b0;

            if (w_grant_vid || w_grant_dcs)
                r_wait_cnt <= 16'd0;
            else if (r_state == CMD_VID || r_state == CMD_DCS)
                r_wait_cnt <= r_wait_cnt + 16'd1;

            if (w_grant_vid || w_grant_dcs)
                host.host_tx_cmd_req <= 1'b1;
            else if (w_vid_done || w_dcs_done || w_timeout)
                host.host_tx_cmd_req <= 1'b0;

            if (w_grant_vid) begin
                host.host_tx_cmd_data_type  <= vid_data_type;
                host.host_tx_cmd_byte_count <= vid_byte_count;
            end else if (w_grant_dcs) begin
                host.host_tx_cmd_data_type  <= dcs_data_type;
                host.host_tx_cmd_byte_count <= dcs_word;
            end

            if (w_timeout && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign grant_vid = (r_state == CMD_VID) || (r_state == DATA_VID);
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mipi_tx_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mipi_tx_cmd_arbiter
// Description : Directed self-checking bench for mipi_tx_cmd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mipi_tx_cmd_arbiter;

    logic        clk_periph = 1'b0;
    logic        rstn       = 1'b1;
    logic        frame_start;
    logic        vid_req;
    logic [5:0]  vid_data_type;
    logic [15:0] vid_byte_count;
    logic        vid_ack;
    logic        dcs_req;
    logic [5:0]  dcs_data_type;
    logic [15:0] dcs_word;
    logic        dcs_ack;
    logic        grant_vid;
    logic        busy;
    logic        timeout_pulse;
    logic [7:0]  err_cnt;

    int vectors    = 0;
    int miscompares = 0;
    logic ack_seen;

    mipi_tx_cmd_arbiter_if host_if ();

    mipi_tx_cmd_arbiter #(.TIMEOUT(8)) dut (
        .clk_periph     (clk_periph),
        .rstn           (rstn),
        .frame_start    (frame_start),
        .vid_req        (vid_req),
        .vid_data_type  (vid_data_type),
        .vid_byte_count (vid_byte_count),
        .vid_ack        (vid_ack),
        .dcs_req        (dcs_req),
        .dcs_data_type  (dcs_data_type),
        .dcs_word       (dcs_word),
        .dcs_ack        (dcs_ack),
        .host           (host_if),
        .grant_vid      (grant_vid),
        .busy           (busy),
        .timeout_pulse  (timeout_pulse),
        .err_cnt        (err_cnt)
    );

    always #5 clk_periph = ~clk_periph;

    task automatic tick;
        @(posedge clk_periph);
        @(negedge clk_periph);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        frame_start    = 1'b0;
        vid_req        = 1'b0;
        vid_data_type  = 6'd0;
        vid_byte_count = 16'd0;
        dcs_req        = 1'b0;
        dcs_data_type  = 6'd0;
        dcs_word       = 16'd0;
        host_if.host_tx_cmd_ack         = 1'b0;
        host_if.host_tx_payload_en_last = 1'b0;

        // asynchronous reset, checked before any clock edge
        #1 rstn = 1'b0;
        #2;
        check("rst_req",   host_if.host_tx_cmd_req, 0);
        check("rst_dtype", host_if.host_tx_cmd_data_type, 0);
        check("rst_bcnt",  host_if.host_tx_cmd_byte_count, 0);
        check("rst_busy",  busy, 0);
        check("rst_gvid",  grant_vid, 0);
        check("rst_acks",  {vid_ack, dcs_ack, timeout_pulse}, 0);
        check("rst_err",   err_cnt, 0);

        @(negedge clk_periph);
        @(negedge clk_periph);
        rstn           = 1'b1;
        vid_req        = 1'b1;
        vid_data_type  = 6'h3E;
        vid_byte_count = 16'd5760;
        tick;
        check("post_rst_edge1_busy", busy, 0);
        tick;
        check("vid_req_up",   host_if.host_tx_cmd_req, 1);
        check("vid_dtype",    host_if.host_tx_cmd_data_type, 6'h3E);
        check("vid_bcnt",     host_if.host_tx_cmd_byte_count, 16'd5760);
        check("vid_grant",    grant_vid, 1);
        tick;
        tick;
        check("vid_no_early_ack", vid_ack, 0);
        check("vid_dtype_hold",   host_if.host_tx_cmd_data_type, 6'h3E);
        host_if.host_tx_cmd_ack = 1'b1;
        tick;
        check("vid_ack_pulse",    vid_ack, 1);
        check("vid_req_drop",     host_if.host_tx_cmd_req, 0);
        check("vid_data_busy",    {busy, grant_vid}, 2'b11);
        host_if.host_tx_cmd_ack = 1'b0;
        vid_req = 1'b0;
        tick;
        check("vid_ack_once",     vid_ack, 0);
        check("vid_data_busy2",   busy, 1);
        host_if.host_tx_payload_en_last = 1'b1;
        tick;
        host_if.host_tx_payload_en_last = 1'b0;
        check("vid_done_idle",    {busy, grant_vid}, 2'b00);

        // ack/last while idle must not start anything
        host_if.host_tx_cmd_ack = 1'b1;
        host_if.host_tx_payload_en_last = 1'b1;
        tick;
        tick;
        check("idle_ignore", {busy, vid_ack, dcs_ack, host_if.host_tx_cmd_req}, 0);
        host_if.host_tx_cmd_ack = 1'b0;
        host_if.host_tx_payload_en_last = 1'b0;

        // vblank: DCS wins, then video after an idle cycle
        frame_start = 1'b1;
        tick;
        frame_start    = 1'b0;
        vid_req        = 1'b1;
        vid_byte_count = 16'd100;
        dcs_req        = 1'b1;
        dcs_data_type  = 6'h15;
        dcs_word       = 16'h0051;
        tick;
        check("vb_dcs_first", {busy, grant_vid, host_if.host_tx_cmd_req}, 3'b101);
        check("vb_dcs_dtype", host_if.host_tx_cmd_data_type, 6'h15);
        check("vb_dcs_word",  host_if.host_tx_cmd_byte_count, 16'h0051);
        host_if.host_tx_cmd_ack = 1'b1;
        tick;
        host_if.host_tx_cmd_ack = 1'b0;
        dcs_req = 1'b0;
        check("vb_dcs_ack",   {dcs_ack, vid_ack, host_if.host_tx_cmd_req, busy}, 4'b1000);
        tick;
        check("vb_vid_next",  {grant_vid, host_if.host_tx_cmd_req}, 2'b11);
        check("vb_vid_bcnt",  host_if.host_tx_cmd_byte_count, 16'd100);
        host_if.host_tx_cmd_ack = 1'b1;
        tick;
        host_if.host_tx_cmd_ack = 1'b0;
        vid_req = 1'b0;
        check("vb_vid_ack",   vid_ack, 1);
        host_if.host_tx_payload_en_last = 1'b1;
        tick;
        host_if.host_tx_payload_en_last = 1'b0;
        check("vb_vid_done",  busy, 0);

        // no vblank: video wins, DCS after DATA_VID ends
        vid_req = 1'b1;
        dcs_req = 1'b1;
        tick;
        check("nv_vid_first", {grant_vid, host_if.host_tx_cmd_data_type}, {1'b1, 6'h3E});
        host_if.host_tx_cmd_ack = 1'b1;
        tick;
        host_if.host_tx_cmd_ack = 1'b0;
        vid_req = 1'b0;
        check("nv_vid_ack",   {vid_ack, dcs_ack}, 2'b10);
        host_if.host_tx_payload_en_last = 1'b1;
        tick;
        host_if.host_tx_payload_en_last = 1'b0;
        check("nv_idle_gap",  busy, 0);
        tick;
        check("nv_dcs_next",  {busy, grant_vid, host_if.host_tx_cmd_data_type}, {2'b10, 6'h15});
        host_if.host_tx_cmd_ack = 1'b1;
        tick;
        host_if.host_tx_cmd_ack = 1'b0;
        dcs_req = 1'b0;
        check("nv_dcs_ack",   dcs_ack, 1);
        tick;

        // ack on the very cycle the timeout is reached counts as an ack
        vid_req = 1'b1;
        tick;
        check("race_req_up",  host_if.host_tx_cmd_req, 1);
        repeat (7) tick;
        host_if.host_tx_cmd_ack = 1'b1;
        tick;
        host_if.host_tx_cmd_ack = 1'b0;
        vid_req = 1'b0;
        check("race_ack",     {vid_ack, timeout_pulse, host_if.host_tx_cmd_req, busy}, 4'b1001);
        host_if.host_tx_payload_en_last = 1'b1;
        tick;
        host_if.host_tx_payload_en_last = 1'b0;
        check("race_err",     {busy, err_cnt}, 9'd0);

        // timeout: req high for exactly 8 cycles
        vid_req = 1'b1;
        tick;
        check("to_req_up",    host_if.host_tx_cmd_req, 1);
        repeat (7) tick;
        check("to_req_c7",    {host_if.host_tx_cmd_req, timeout_pulse}, 2'b10);
        tick;
        check("to_drop",      {host_if.host_tx_cmd_req, timeout_pulse, vid_ack, busy}, 4'b0100);
        check("to_err1",      err_cnt, 1);
        vid_req = 1'b0;
        tick;
        check("to_pulse_once", timeout_pulse, 0);

        // 299 more timeouts saturate the error counter
        vid_req  = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 299; i++) begin
            int n;
            n = 0;
            do begin
                tick;
                n++;
                if (vid_ack) ack_seen = 1'b1;
            end while (!timeout_pulse && n < 20);
            if (!timeout_pulse) begin
                check("to_loop_wait_expired", timeout_pulse, 1);
                break;
            end
        end
        vid_req = 1'b0;
        check("to_err_sat",   err_cnt, 8'd255);
        check("to_no_ack",    ack_seen, 0);
        tick;
        tick;

        // reset in DATA_VID, then a clean transaction
        vid_req        = 1'b1;
        vid_byte_count = 16'd3;
        tick;
        host_if.host_tx_cmd_ack = 1'b1;
        tick;
        host_if.host_tx_cmd_ack = 1'b0;
        vid_req = 1'b0;
        check("mid_in_data",  {busy, grant_vid}, 2'b11);
        rstn = 1'b0;
        #1;
        check("mid_rst_all0", {host_if.host_tx_cmd_req, busy, grant_vid, vid_ack,
                               dcs_ack, timeout_pulse, err_cnt}, 0);
        check("mid_rst_bus0", {host_if.host_tx_cmd_data_type, host_if.host_tx_cmd_byte_count}, 0);
        @(negedge clk_periph);
        rstn           = 1'b1;
        vid_req        = 1'b1;
        vid_data_type  = 6'h2C;
        tick;
        check("rec_edge1",    busy, 0);
        tick;
        check("rec_req",      {host_if.host_tx_cmd_req, host_if.host_tx_cmd_data_type,
                               host_if.host_tx_cmd_byte_count}, {1'b1, 6'h2C, 16'd3});
        host_if.host_tx_cmd_ack = 1'b1;
        tick;
        host_if.host_tx_cmd_ack = 1'b0;
        vid_req = 1'b0;
        check("rec_ack",      vid_ack, 1);
        host_if.host_tx_payload_en_last = 1'b1;
        tick;
        host_if.host_tx_payload_en_last = 1'b0;
        check("rec_done",     {busy, err_cnt}, 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
